trig_sched: RTL

//  Round-robin scheduler that shares one signal_trig instance between NUM_REQ requesters
//  (e.g. the two HDMI output channels). Latches trigger requests and grants one at a time.
//  For each grant it drives a fixed-width pulse into signal_trig and waits for its response.
//  It then enforces a hold-off gap before the next grant.

---
 rtl/trig_sched_pkg.sv | 24 ++
 rtl/trig_rr_pick.sv | 25 ++
 rtl/trig_sched.sv | 137 +++++++++++++
 3 files changed

// File: rtl/trig_sched_pkg.sv
// Shared types and elaboration-time helpers for the trigger scheduler.
package trig_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PULSE    = 2'd1,
    S_WAIT_ACK = 2'd2,
    S_HOLD     = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/trig_rr_pick.sv
// Round-robin picker: first set bit of pend searching upward from last+1, wrapping at N.
module trig_rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] pend,
  input  logic [W-1:0] last,
  output logic [W-1:0] idx,
  output logic         any
);

  // Walk from the farthest candidate back to the nearest so the nearest set bit wins.
  always_comb begin
    logic [W-1:0] pos;
    pos = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      pos = W'((int'(last) + k) % N);
      if (pend[pos]) idx = pos;
    end
  end

  assign any = |pend;

endmodule

// File: rtl/trig_sched.sv
// Round-robin scheduler sharing one signal_trig between NUM_REQ requesters:
// pulse, wait for ack (or time out), hold off, then grant the next pending requester.
module trig_sched
  import trig_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PULSE_W = 4,
  parameter int ACK_TO  = 64,
  parameter int HOLDOFF = 16,
  parameter int ID_W    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic               trig_out,
  input  logic               trig_ack,
  output logic               grant_vld,
  output logic [ID_W-1:0]    grant_id,
  output logic               done,
  output logic               timeout,
  output logic [NUM_REQ-1:0] drop,
  output logic               busy
);

  localparam int CNT_W = clog2(max3(PULSE_W, ACK_TO, HOLDOFF) + 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [NUM_REQ-1:0] pend_reg, pend_clr;
  logic [ID_W-1:0]    last_reg, pick_idx;
  logic               pick_any, grant_fire;
  logic               trig_next, done_next, timeout_next, busy_next;

  trig_rr_pick #(.N(NUM_REQ), .W(ID_W)) u_pick (
    .pend (pend_reg),
    .last (last_reg),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign grant_fire = (state_reg == S_IDLE) && en && pick_any;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_clr
      assign pend_clr[gi] = grant_fire && (pick_idx == ID_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (en && pick_any) begin
          state_next = S_PULSE;
          cnt_next   = '0;
        end
      end
      S_PULSE: begin
        if (cnt_reg == CNT_W'(PULSE_W - 1)) begin
          state_next = S_WAIT_ACK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_WAIT_ACK: begin
        if (trig_ack || (cnt_reg == CNT_W'(ACK_TO - 1))) begin
          state_next = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_reg == CNT_W'(HOLDOFF - 1)) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // An ack on the final wait cycle takes priority over the timeout.
  always_comb begin
    trig_next    = (state_next == S_PULSE);
    done_next    = (state_reg == S_WAIT_ACK) && trig_ack;
    timeout_next = (state_reg == S_WAIT_ACK) && !trig_ack &&
                   (cnt_reg == CNT_W'(ACK_TO - 1));
    busy_next    = (state_next != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_out  <= 1'b0;
      grant_vld <= 1'b0;
      grant_id  <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      drop      <= '0;
      busy      <= 1'b0;
      pend_reg  <= '0;
      last_reg  <= ID_W'(NUM_REQ - 1);
    end else begin
      trig_out  <= trig_next;
      grant_vld <= grant_fire;
      done      <= done_next;
      timeout   <= timeout_next;
      busy      <= busy_next;
      // A new request on the bit being granted this cycle re-arms it without a drop.
      drop      <= req & pend_reg & ~pend_clr;
      pend_reg  <= (pend_reg & ~pend_clr) | req;
      if (grant_fire) begin
        grant_id <= pick_idx;
        last_reg <= pick_idx;
      end
    end
  end

endmodule
